// File: rtl/axi_cache_arbiter_pkg.sv
// Shared constants and FSM state encodings for the I$/D$ to AXI arbiter.
package axi_cache_arbiter_pkg;

    localparam int unsigned AXI_ID_W = 4;

    localparam logic [1:0]          AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_ID_W-1:0] AXI_ID_INST    = 4'd0;
    localparam logic [AXI_ID_W-1:0] AXI_ID_DATA    = 4'd1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_AW,
        W_DATA,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/axi_cache_arbiter.sv
// Merges I$ and D$ read misses and D$ writes onto one AXI master port.
// One outstanding read and one outstanding write; D-side accesses stay ordered.
module axi_cache_arbiter
    import axi_cache_arbiter_pkg::*;
#(
    parameter int unsigned         ADDR_W  = 32,
    parameter int unsigned         DATA_W  = 32,
    parameter logic [AXI_ID_W-1:0] INST_ID = AXI_ID_INST,
    parameter logic [AXI_ID_W-1:0] DATA_ID = AXI_ID_DATA
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // instruction cache read client
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [7:0]            i_len,
    input  logic [2:0]            i_size,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic                  i_rlast,
    // data cache read client
    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [7:0]            d_len,
    input  logic [2:0]            d_size,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic                  d_rlast,
    output logic [DATA_W-1:0]     c_rdata,
    // data cache write client
    input  logic                  dw_req,
    input  logic [ADDR_W-1:0]     dw_addr,
    input  logic [7:0]            dw_len,
    input  logic [2:0]            dw_size,
    output logic                  dw_gnt,
    input  logic [DATA_W-1:0]     dw_wdata,
    input  logic [DATA_W/8-1:0]   dw_wstrb,
    output logic                  dw_wnext,
    output logic                  dw_done,
    // AXI read address
    output logic [AXI_ID_W-1:0]   arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    // AXI read data
    input  logic [AXI_ID_W-1:0]   rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    // AXI write address
    output logic [AXI_ID_W-1:0]   awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    // AXI write data
    output logic [AXI_ID_W-1:0]   wid,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    // AXI write response
    input  logic [AXI_ID_W-1:0]   bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    rd_state_e             r_state_q, r_state_d;
    logic [AXI_ID_W-1:0]   arid_q, arid_d;
    logic [ADDR_W-1:0]     araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  i_gnt_q, i_gnt_d;
    logic                  d_gnt_q, d_gnt_d;

    wr_state_e             w_state_q, w_state_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [2:0]            awsize_q, awsize_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  dw_gnt_q, dw_gnt_d;
    logic [7:0]            cnt_q, cnt_d;

    logic d_rd_win;
    logic rd_blocks_wr;
    logic r_beat;
    logic w_beat;
    logic unused_resp;

    // A D-side read waits for any write in flight; a D-side write waits for a
    // D-side read in flight. On a same-cycle D read/write tie the read goes first.
    assign d_rd_win     = (r_state_q == R_IDLE) && d_req && (w_state_q == W_IDLE);
    assign rd_blocks_wr = d_rd_win || ((r_state_q != R_IDLE) && (arid_q == DATA_ID));

    assign r_beat   = rvalid && rready_q;
    assign w_beat   = wvalid_q && wready;

    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_rvalid = r_beat && (rid == INST_ID);
    assign d_rvalid = r_beat && (rid != INST_ID);
    assign i_rlast  = i_rvalid && rlast;
    assign d_rlast  = d_rvalid && rlast;
    assign c_rdata  = rdata;

    assign arid     = arid_q;
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arsize   = arsize_q;
    assign arburst  = AXI_BURST_INCR;
    assign arlock   = '0;
    assign arcache  = '0;
    assign arprot   = '0;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;

    assign awid     = DATA_ID;
    assign awaddr   = awaddr_q;
    assign awlen    = awlen_q;
    assign awsize   = awsize_q;
    assign awburst  = AXI_BURST_INCR;
    assign awlock   = '0;
    assign awcache  = '0;
    assign awprot   = '0;
    assign awvalid  = awvalid_q;

    // Write data is a pass-through of the client's current beat; only the
    // handshake-side controls (valid/last) come from registered state.
    assign wid      = DATA_ID;
    assign wdata    = dw_wdata;
    assign wstrb    = dw_wstrb;
    assign wvalid   = wvalid_q;
    assign wlast    = wvalid_q && (cnt_q == awlen_q);
    assign bready   = bready_q;
    assign dw_gnt   = dw_gnt_q;
    assign dw_wnext = w_beat;
    assign dw_done  = bvalid && bready_q;

    assign unused_resp = ^{rresp, bresp, bid};

    // Read FSM next-state: arbitrate, issue AR, then stream R beats until rlast.
    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        i_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (d_rd_win) begin
                    arid_d    = DATA_ID;
                    araddr_d  = d_addr;
                    arlen_d   = d_len;
                    arsize_d  = d_size;
                    arvalid_d = 1'b1;
                    d_gnt_d   = 1'b1;
                    r_state_d = R_AR;
                end else if (i_req) begin
                    arid_d    = INST_ID;
                    araddr_d  = i_addr;
                    arlen_d   = i_len;
                    arsize_d  = i_size;
                    arvalid_d = 1'b1;
                    i_gnt_d   = 1'b1;
                    r_state_d = R_AR;
                end
            end
            R_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_beat && rlast) begin
                    rready_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read path registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            i_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            i_gnt_q   <= i_gnt_d;
            d_gnt_q   <= d_gnt_d;
        end
    end

    // Write FSM next-state: issue AW, stream W beats, then wait for B.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        dw_gnt_d  = 1'b0;
        cnt_d     = cnt_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (dw_req && !rd_blocks_wr) begin
                    awaddr_d  = dw_addr;
                    awlen_d   = dw_len;
                    awsize_d  = dw_size;
                    awvalid_d = 1'b1;
                    dw_gnt_d  = 1'b1;
                    cnt_d     = '0;
                    w_state_d = W_AW;
                end
            end
            W_AW: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (wlast) begin
                        wvalid_d  = 1'b0;
                        bready_d  = 1'b1;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    bready_d  = 1'b0;
                    cnt_d     = '0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write path registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            dw_gnt_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            dw_gnt_q  <= dw_gnt_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
